// File: rtl/pio_ctrl_core.sv
// pio_ctrl_core: PIO bus register file, instruction memory, SM0 clock divider.
// Optional `PIO_IMEM_READBACK_EN adds a bus read port onto INSTR_MEM words.
module pio_ctrl_core #(
  parameter int IMEM_DEPTH = 32,
  parameter int IMEM_W     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sel,
  input  logic                          RW,
  input  logic [11:0]                   addr,
  input  logic [31:0]                   wdata,
  output logic [31:0]                   rdata,
  output logic                          busy,
  input  logic [$clog2(IMEM_DEPTH)-1:0] pc,
  input  logic                          rd,
  output logic [IMEM_W-1:0]             instr_rdata,
  output logic                          instr_valid,
  output logic                          sm_enable,
  output logic                          sm_restart,
  output logic [4:0]                    wrap_top,
  output logic [4:0]                    wrap_bottom,
  output logic                          force_we,
  output logic [15:0]                   force_instr,
  output logic                          penable
);

  localparam int AW = $clog2(IMEM_DEPTH);

  localparam logic [11:0] A_CTRL  = 12'h000;
  localparam logic [11:0] A_IMEM  = 12'h048;
  localparam logic [11:0] A_DIV   = 12'h0C8;
  localparam logic [11:0] A_EXEC  = 12'h0CC;
  localparam logic [11:0] A_SHIFT = 12'h0D0;
  localparam logic [11:0] A_ADDR  = 12'h0D4;
  localparam logic [11:0] A_INSTR = 12'h0D8;

  localparam logic [11:0] A_IMEM_LAST =
    12'(A_IMEM + 12'(4 * (IMEM_DEPTH - 1)));
  localparam logic [AW-1:0] IMEM_BASE_W =
    AW'(A_IMEM >> 2);

  logic [3:0]  ctrl_en;
  logic [15:0] clkdiv_int;
  logic [7:0]  clkdiv_frac;
  logic [31:0] execctrl;
  logic [31:0] shiftctrl;

  logic [IMEM_W-1:0] imem [IMEM_DEPTH];

  logic bus_wr;
  logic bus_rd;
  assign bus_wr = sel & RW & ~reset;
  assign bus_rd = sel & ~RW & ~reset;

  logic hit_ctrl;
  logic hit_div;
  logic hit_exec;
  logic hit_shift;
  logic hit_addr;
  logic hit_instr;
  logic hit_imem;

  assign hit_ctrl  = (addr == A_CTRL);
  assign hit_div   = (addr == A_DIV);
  assign hit_exec  = (addr == A_EXEC);
  assign hit_shift = (addr == A_SHIFT);
  assign hit_addr  = (addr == A_ADDR);
  assign hit_instr = (addr == A_INSTR);
  assign hit_imem  = (addr >= A_IMEM)
                   && (addr <= A_IMEM_LAST)
                   && (addr[1:0] == 2'b00);

  // Word index relative to the INSTR_MEM base.
  logic [AW-1:0] widx;
  assign widx = addr[AW+1:2] - IMEM_BASE_W;

  assign sm_enable   = ctrl_en[0];
  assign wrap_top    = execctrl[16:12];
  assign wrap_bottom = execctrl[11:7];
  assign busy        = bus_rd;

  assign force_we    = bus_wr & hit_instr;
  assign force_instr = force_we ? wdata[15:0] : 16'h0;

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      hit_ctrl:  rd_val = {28'b0, ctrl_en};
      hit_div:   rd_val = {clkdiv_int, clkdiv_frac, 8'b0};
      hit_exec:  rd_val = execctrl;
      hit_shift: rd_val = shiftctrl;
      hit_addr:  rd_val = 32'(pc);
`ifdef PIO_IMEM_READBACK_EN
      hit_imem:  rd_val = 32'(imem[widx]);
`endif
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en     <= '0;
      clkdiv_int  <= 16'd1;
      clkdiv_frac <= '0;
      execctrl    <= 32'h0001_F000;
      shiftctrl   <= 32'h000C_0000;
      sm_restart  <= 1'b0;
      rdata       <= '0;
      instr_valid <= 1'b0;
    end else begin
      sm_restart  <= bus_wr & hit_ctrl & wdata[4];
      instr_valid <= rd;
      if (bus_wr & hit_ctrl)
        ctrl_en <= wdata[3:0];
      if (bus_wr & hit_div) begin
        clkdiv_int  <= wdata[31:16];
        clkdiv_frac <= wdata[15:8];
      end
      if (bus_wr & hit_exec)
        execctrl <= wdata;
      if (bus_wr & hit_shift)
        shiftctrl <= wdata;
      if (bus_rd)
        rdata <= rd_val;
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (bus_wr & hit_imem)
      imem[widx] <= wdata[IMEM_W-1:0];
    if (rd)
      instr_rdata <= imem[pc];
  end

  logic [23:0] div;
  logic [24:0] acc;
  logic [24:0] acc_sum;
  logic        div_bypass;
  logic        acc_wrap;
  logic        div_clear;

  assign div        = {clkdiv_int, clkdiv_frac};
  assign acc_sum    = acc + 25'd256;
  assign div_bypass = (clkdiv_int < 16'd2);
  assign acc_wrap   = (acc_sum >= {1'b0, div});
  assign penable    = div_bypass | acc_wrap;

  assign div_clear = bus_wr
                   & (hit_div | (hit_ctrl & wdata[8]));

  always_ff @(posedge clk) begin
    if (reset || div_clear || div_bypass)
      acc <= '0;
    else if (acc_wrap)
      acc <= acc_sum - {1'b0, div};
    else
      acc <= acc_sum;
  end

endmodule

// File: tb/tb_pio_ctrl_core.sv
// tb_pio_ctrl_core: directed checks of the PIO register/control core.
// Inputs change on negedge; outputs are sampled on negedge or #1 after.
module tb_pio_ctrl_core;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        RW;
  logic [11:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic [4:0]  pc;
  logic        rd;
  logic [15:0] instr_rdata;
  logic        instr_valid;
  logic        sm_enable;
  logic        sm_restart;
  logic [4:0]  wrap_top;
  logic [4:0]  wrap_bottom;
  logic        force_we;
  logic [15:0] force_instr;
  logic        penable;

  int total;
  int bad;

  pio_ctrl_core dut (
    .clk         (clk),
    .reset       (reset),
    .sel         (sel),
    .RW          (RW),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .busy        (busy),
    .pc          (pc),
    .rd          (rd),
    .instr_rdata (instr_rdata),
    .instr_valid (instr_valid),
    .sm_enable   (sm_enable),
    .sm_restart  (sm_restart),
    .wrap_top    (wrap_top),
    .wrap_bottom (wrap_bottom),
    .force_we    (force_we),
    .force_instr (force_instr),
    .penable     (penable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout reached, no summary");
    $fatal(1, "timeout");
  end

  task automatic bus_write(input logic [11:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    sel = 1'b1; RW = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    sel = 1'b0; RW = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a,
                          output logic [31:0] v);
    @(negedge clk);
    sel = 1'b1; RW = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    v = rdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++;
    if (penable !== 1'b1) begin
      bad++;
      $display("FAIL reset_penable: got %b want 1", penable);
    end
    total++;
    if ({sm_enable, sm_restart, force_we, instr_valid, busy}
        !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 00000",
        {sm_enable, sm_restart, force_we, instr_valid, busy});
    end
    total++;
    if (rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    total++;
    if ({wrap_top, wrap_bottom} !== {5'd31, 5'd0}) begin
      bad++;
      $display("FAIL reset_wrap: got %0d/%0d want 31/0",
        wrap_top, wrap_bottom);
    end
    bus_read(12'h0C8, v);
    total++;
    if (v !== 32'h0001_0000) begin
      bad++;
      $display("FAIL reset_clkdiv: got %h want 00010000", v);
    end
    bus_read(12'h0CC, v);
    total++;
    if (v !== 32'h0001_F000) begin
      bad++;
      $display("FAIL reset_exec: got %h want 0001f000", v);
    end
    bus_read(12'h0D0, v);
    total++;
    if (v !== 32'h000C_0000) begin
      bad++;
      $display("FAIL reset_shift: got %h want 000c0000", v);
    end
    bus_read(12'h000, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL reset_ctrl: got %h want 0", v);
    end
  endtask

  task automatic test_imem;
    logic [31:0] v;
    bus_write(12'h054, 32'h0000_E081);
    @(negedge clk);
    pc = 5'd3; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || instr_rdata !== 16'hE081) begin
      bad++;
      $display("FAIL imem_fetch: got v=%b d=%h want 1/e081",
        instr_valid, instr_rdata);
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL imem_valid_drop: got %b want 0",
        instr_valid);
    end
    bus_write(12'h05C, 32'h0000_1111);
    @(negedge clk);
    sel = 1'b1; RW = 1'b1; addr = 12'h05C;
    wdata = 32'h0000_2222; pc = 5'd5; rd = 1'b1;
    @(negedge clk);
    sel = 1'b0; RW = 1'b0;
    total++;
    if (instr_rdata !== 16'h1111) begin
      bad++;
      $display("FAIL imem_rw_same: got %h want 1111",
        instr_rdata);
    end
    @(negedge clk);
    rd = 1'b0;
    total++;
    if (instr_rdata !== 16'h2222) begin
      bad++;
      $display("FAIL imem_new: got %h want 2222", instr_rdata);
    end
    bus_write(12'h0C4, 32'hFFFF_BEEF);
    @(negedge clk);
    pc = 5'd31; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    total++;
    if (instr_rdata !== 16'hBEEF) begin
      bad++;
      $display("FAIL imem_last: got %h want beef", instr_rdata);
    end
    bus_read(12'h054, v);
    total++;
`ifdef PIO_IMEM_READBACK_EN
    if (v !== 32'h0000_E081) begin
      bad++;
      $display("FAIL imem_readback: got %h want 0000e081", v);
    end
`else
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL imem_readback: got %h want 0", v);
    end
`endif
  endtask

  task automatic test_clkdiv;
    logic [31:0] v;
    logic [9:0]  obs;
    bus_write(12'h0C8, 32'h0004_0000);
    obs = '0;
    for (int i = 0; i < 8; i++) begin
      obs[i] = penable;
      @(negedge clk);
    end
    total++;
    if (obs[7:0] !== 8'b1000_1000) begin
      bad++;
      $display("FAIL div4: got %b want 10001000", obs[7:0]);
    end
    bus_write(12'h0C8, 32'h0002_80FF);
    obs = '0;
    for (int i = 0; i < 10; i++) begin
      obs[i] = penable;
      @(negedge clk);
    end
    total++;
    if (obs !== 10'b10_1001_0100) begin
      bad++;
      $display("FAIL div2p5: got %b want 1010010100", obs);
    end
    bus_read(12'h0C8, v);
    total++;
    if (v !== 32'h0002_8000) begin
      bad++;
      $display("FAIL div_read: got %h want 00028000", v);
    end
    bus_write(12'h0C8, 32'h0004_0000);
    repeat (2) @(negedge clk);
    bus_write(12'h000, 32'h0000_0100);
    obs = '0;
    for (int i = 0; i < 4; i++) begin
      obs[i] = penable;
      @(negedge clk);
    end
    total++;
    if (obs[3:0] !== 4'b1000) begin
      bad++;
      $display("FAIL div_restart: got %b want 1000", obs[3:0]);
    end
    bus_write(12'h0C8, 32'h0001_0000);
    obs = '0;
    for (int i = 0; i < 3; i++) begin
      obs[i] = penable;
      @(negedge clk);
    end
    total++;
    if (obs[2:0] !== 3'b111) begin
      bad++;
      $display("FAIL div_bypass: got %b want 111", obs[2:0]);
    end
  endtask

  task automatic test_ctrl;
    logic [31:0] v;
    @(negedge clk);
    sel = 1'b1; RW = 1'b1; addr = 12'h000; wdata = 32'h11;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL write_busy: got %b want 0", busy);
    end
    @(negedge clk);
    sel = 1'b0; RW = 1'b0;
    total++;
    if (sm_enable !== 1'b1 || sm_restart !== 1'b1) begin
      bad++;
      $display("FAIL ctrl_pulse: got en=%b rs=%b want 1/1",
        sm_enable, sm_restart);
    end
    @(negedge clk);
    total++;
    if (sm_restart !== 1'b0) begin
      bad++;
      $display("FAIL ctrl_pulse_end: got %b want 0", sm_restart);
    end
    bus_read(12'h000, v);
    total++;
    if (v !== 32'h1) begin
      bad++;
      $display("FAIL ctrl_read: got %h want 1", v);
    end
  endtask

  task automatic test_force;
    logic [31:0] v;
    @(negedge clk);
    sel = 1'b1; RW = 1'b1; addr = 12'h0D8;
    wdata = 32'h0000_A042;
    #1;
    total++;
    if (force_we !== 1'b1 || force_instr !== 16'hA042) begin
      bad++;
      $display("FAIL force_on: got we=%b i=%h want 1/a042",
        force_we, force_instr);
    end
    @(negedge clk);
    sel = 1'b0; RW = 1'b0;
    #1;
    total++;
    if (force_we !== 1'b0) begin
      bad++;
      $display("FAIL force_off: got %b want 0", force_we);
    end
    bus_read(12'h0D8, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL instr_read: got %h want 0", v);
    end
    pc = 5'd7;
    bus_read(12'h0D4, v);
    total++;
    if (v !== 32'h7) begin
      bad++;
      $display("FAIL addr_read: got %h want 7", v);
    end
  endtask

  task automatic test_exec;
    logic [31:0] v;
    bus_write(12'h0CC, 32'h0000_A380);
    total++;
    if (wrap_top !== 5'd10 || wrap_bottom !== 5'd7) begin
      bad++;
      $display("FAIL wrap: got %0d/%0d want 10/7",
        wrap_top, wrap_bottom);
    end
    bus_write(12'h0D0, 32'h1234_5678);
    bus_write(12'h0FC, 32'hDEAD_BEEF);
    bus_read(12'h0D0, v);
    total++;
    if (v !== 32'h1234_5678) begin
      bad++;
      $display("FAIL shift_rw: got %h want 12345678", v);
    end
    bus_read(12'h0FC, v);
    total++;
    if (v !== 32'h0) begin
      bad++;
      $display("FAIL unmapped: got %h want 0", v);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] v;
    bus_read(12'h0CC, v);
    @(negedge clk);
    sel = 1'b1; RW = 1'b0; addr = 12'h0D0;
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL read_busy: got %b want 1", busy);
    end
    @(negedge clk);
    addr = 12'h0CC;
    total++;
    if (rdata !== 32'h1234_5678) begin
      bad++;
      $display("FAIL b2b_first: got %h want 12345678", rdata);
    end
    @(negedge clk);
    sel = 1'b0;
    total++;
    if (rdata !== 32'h0000_A380) begin
      bad++;
      $display("FAIL b2b_second: got %h want 0000a380", rdata);
    end
    bus_write(12'h0D0, 32'h0);
    repeat (2) @(negedge clk);
    total++;
    if (rdata !== 32'h0000_A380) begin
      bad++;
      $display("FAIL rdata_hold: got %h want 0000a380", rdata);
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] v;
    bus_write(12'h0C8, 32'h0004_0000);
    @(negedge clk);
    reset = 1'b1;
    sel = 1'b1; RW = 1'b0; addr = 12'h0CC;
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    @(negedge clk);
    RW = 1'b1; wdata = 32'h0;
    @(negedge clk);
    reset = 1'b0; sel = 1'b0; RW = 1'b0;
    total++;
    if (rdata !== 32'h0 || penable !== 1'b1) begin
      bad++;
      $display("FAIL abort_state: got rd=%h pe=%b want 0/1",
        rdata, penable);
    end
    bus_read(12'h0CC, v);
    total++;
    if (v !== 32'h0001_F000) begin
      bad++;
      $display("FAIL abort_exec: got %h want 0001f000", v);
    end
    @(negedge clk);
    pc = 5'd3; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    total++;
    if (instr_rdata !== 16'hE081) begin
      bad++;
      $display("FAIL imem_kept: got %h want e081", instr_rdata);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    sel   = 1'b0;
    RW    = 1'b0;
    addr  = '0;
    wdata = '0;
    pc    = '0;
    rd    = 1'b0;
    test_reset;
    test_imem;
    test_clkdiv;
    test_ctrl;
    test_force;
    test_exec;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
